// File: rtl/scaler_pkg.sv
// ============================================================================
// scaler_pkg -- shared types and constants for the horizontal scaler. Rev 1.0
// ============================================================================
`default_nettype none

package scaler_pkg;

  localparam int DEFAULT_PIXEL_STEP = 4096;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV     = 2'd1,
    WAIT_VS = 2'd2
  } ctrl_state_t;

  function automatic int frac_bits(input int pixel_step);
    return $clog2(pixel_step);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_divider_u.sv
// ============================================================================
// seq_divider_u -- unsigned restoring divider, one quotient bit per cycle. Rev 1.0
// ============================================================================
`default_nettype none

module seq_divider_u #(
  parameter int NUM_WIDTH = 23,
  parameter int DEN_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [DEN_WIDTH-1:0] den,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_WIDTH-1:0] quot
);

  localparam int CNT_WIDTH = $clog2(NUM_WIDTH + 1);

  logic [DEN_WIDTH-1:0] rem;
  logic [DEN_WIDTH-1:0] den_r;
  logic [CNT_WIDTH-1:0] cnt;
  logic [DEN_WIDTH:0]   trial;
  logic [DEN_WIDTH:0]   diff;
  logic                 fits;

  // quot doubles as the dividend shift register: numerator bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    trial = {rem, quot[NUM_WIDTH-1]};
    diff  = trial - {1'b0, den_r};
    fits  = (trial >= {1'b0, den_r});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem   <= '0;
      den_r <= '0;
      cnt   <= '0;
      quot  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quot  <= num;
        rem   <= '0;
        den_r <= den;
        cnt   <= CNT_WIDTH'(NUM_WIDTH);
      end else if (cnt != '0) begin
        rem  <= fits ? diff[DEN_WIDTH-1:0] : trial[DEN_WIDTH-1:0];
        quot <= {quot[NUM_WIDTH-2:0], fits};
        cnt  <= cnt - 1'b1;
        done <= (cnt == CNT_WIDTH'(1));
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

`default_nettype wire

// File: rtl/scaler_h_ctrl.sv
// ============================================================================
// scaler_h_ctrl -- measures input line width, applies scale step at frame start. Rev 1.0
// ============================================================================
`default_nettype none

module scaler_h_ctrl
  import scaler_pkg::*;
#(
  parameter int PIXEL_STEP = DEFAULT_PIXEL_STEP,
  parameter int LINE_WIDTH = 11,
  parameter int STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  input  logic [LINE_WIDTH-1:0] cfg_w_out_i,
  input  logic                  cfg_update_i,
  output logic [STEP_WIDTH-1:0] scale_step_h_o,
  output logic [LINE_WIDTH-1:0] w_in_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int FRAC_BITS = frac_bits(PIXEL_STEP);
  localparam int NUM_WIDTH = LINE_WIDTH + FRAC_BITS;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_DIV     = DIV;
  localparam logic [1:0] ST_WAIT_VS = WAIT_VS;

  localparam logic [STEP_WIDTH-1:0] STEP_UNITY = STEP_WIDTH'(PIXEL_STEP);

  logic [LINE_WIDTH-1:0] pix_cnt;
  logic [LINE_WIDTH-1:0] cand;
  logic                  line_start;
  logic                  frame_start;
  logic                  new_width;
  logic                  w_trig;
  logic                  trigger;

  logic [1:0]            state;
  logic                  div_first;
  logic                  pending;
  logic [LINE_WIDTH-1:0] w_out;
  logic [STEP_WIDTH-1:0] step_shadow;
  logic                  shadow_ovf;
  logic                  bad_operand;

  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [NUM_WIDTH-1:0]  div_num;
  logic [NUM_WIDTH-1:0]  div_quot;
  logic                  quot_ovf;

  assign line_start  = de_i && hs_i;
  assign frame_start = line_start && vs_i;
  // A width is accepted only when two consecutive line captures agree.
  assign new_width   = line_start && (pix_cnt != '0) && (pix_cnt == cand)
                       && (pix_cnt != w_in_o);
  assign trigger     = cfg_update_i || w_trig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      cand    <= '0;
      w_in_o  <= '0;
      w_trig  <= 1'b0;
    end else begin
      w_trig <= new_width;
      if (new_width) w_in_o <= pix_cnt;
      if (line_start) begin
        if (pix_cnt != '0) cand <= pix_cnt;
        pix_cnt <= LINE_WIDTH'(1);
      end else if (de_i && (pix_cnt != '1)) begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  assign bad_operand = (w_out == '0) || (w_in_o == '0);
  assign div_start   = (state == ST_DIV) && div_first && !bad_operand;
  assign div_num     = {w_in_o, {FRAC_BITS{1'b0}}};
  assign quot_ovf    = ((div_quot >> STEP_WIDTH) != '0);

  seq_divider_u #(
    .NUM_WIDTH (NUM_WIDTH),
    .DEN_WIDTH (LINE_WIDTH)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (w_out),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      div_first      <= 1'b0;
      pending        <= 1'b0;
      w_out          <= '0;
      step_shadow    <= STEP_UNITY;
      shadow_ovf     <= 1'b0;
      scale_step_h_o <= STEP_UNITY;
      err_o          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger || pending) begin
            state     <= ST_DIV;
            div_first <= 1'b1;
            w_out     <= cfg_w_out_i;
            pending   <= 1'b0;
          end
        end
        ST_DIV: begin
          div_first <= 1'b0;
          if (trigger) pending <= 1'b1;
          if (div_first && bad_operand) begin
            err_o <= 1'b1;
            state <= ST_IDLE;
          end else if (div_done) begin
            step_shadow <= quot_ovf ? '1 : STEP_WIDTH'(div_quot);
            shadow_ovf  <= quot_ovf;
            state       <= ST_WAIT_VS;
          end
        end
        ST_WAIT_VS: begin
          if (trigger) pending <= 1'b1;
          if (frame_start) begin
            scale_step_h_o <= step_shadow;
            err_o          <= shadow_ovf;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE) || pending || div_busy;

endmodule

`default_nettype wire

// File: tb/tb_scaler_h_ctrl.sv
// ============================================================================
// tb_scaler_h_ctrl -- directed self-checking bench for scaler_h_ctrl. Rev 1.0
// ============================================================================
`default_nettype none

module tb_scaler_h_ctrl;

  logic        clk;
  logic        rst_n;
  logic        de_i;
  logic        hs_i;
  logic        vs_i;
  logic [10:0] cfg_w_out_i;
  logic        cfg_update_i;
  logic [15:0] scale_step_h_o;
  logic [10:0] w_in_o;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  scaler_h_ctrl #(
    .PIXEL_STEP (4096),
    .LINE_WIDTH (11),
    .STEP_WIDTH (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .de_i           (de_i),
    .hs_i           (hs_i),
    .vs_i           (vs_i),
    .cfg_w_out_i    (cfg_w_out_i),
    .cfg_update_i   (cfg_update_i),
    .scale_step_h_o (scale_step_h_o),
    .w_in_o         (w_in_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of video; the update request lasts exactly one beat.
  task automatic pix(input logic de, input logic hs, input logic vs);
    de_i = de;
    hs_i = hs;
    vs_i = vs;
    @(posedge clk);
    #1;
    cfg_update_i = 1'b0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) pix(1'b1, 1'b0, 1'b0);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 1'b0);
  endtask

  task automatic tail(input int w);
    beats(w - 1);
    blank(8);
  endtask

  task automatic lines(input int n, input int w);
    for (int i = 0; i < n; i++) begin
      pix(1'b1, 1'b1, 1'b0);
      tail(w);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    de_i         = 1'b0;
    hs_i         = 1'b0;
    vs_i         = 1'b0;
    cfg_w_out_i  = 11'd18;
    cfg_update_i = 1'b0;
    blank(3);
    chk("rst_step", scale_step_h_o, 4096);
    chk("rst_w_in", w_in_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst_n = 1'b1;

    // Frame 0: measure 24-pixel lines, request w_out = 18
    pix(1'b1, 1'b1, 1'b1);
    tail(24);
    lines(2, 24);
    chk("w_in_24", w_in_o, 24);
    cfg_update_i = 1'b1;
    lines(125, 24);

    // Frame 1: 24*4096/18 = 5461 lands exactly one cycle after the vs beat
    chk("f1_pre_step", scale_step_h_o, 4096);
    chk("f1_pre_busy", busy_o, 1);
    pix(1'b1, 1'b1, 1'b1);
    chk("f1_step_5461", scale_step_h_o, 16'h1555);
    chk("f1_err", err_o, 0);
    tail(24);
    lines(127, 24);

    // Frame 2: pending recompute re-applies, then request w_out = 1
    chk("f2_pre_busy", busy_o, 1);
    pix(1'b1, 1'b1, 1'b1);
    chk("f2_step", scale_step_h_o, 16'h1555);
    chk("f2_busy_idle", busy_o, 0);
    cfg_w_out_i  = 11'd1;
    cfg_update_i = 1'b1;
    tail(24);
    lines(127, 24);

    // Frame 3: 98304 overflows 16 bits -> saturate, err set; then w_out = 24
    chk("f3_pre_step", scale_step_h_o, 16'h1555);
    pix(1'b1, 1'b1, 1'b1);
    chk("f3_step_sat", scale_step_h_o, 16'hFFFF);
    chk("f3_err_ovf", err_o, 1);
    cfg_w_out_i  = 11'd24;
    cfg_update_i = 1'b1;
    tail(24);
    lines(127, 24);

    // Frame 4: unity ratio, err cleared
    pix(1'b1, 1'b1, 1'b1);
    chk("f4_step_unity", scale_step_h_o, 4096);
    chk("f4_err_clr", err_o, 0);
    chk("f4_busy", busy_o, 0);
    tail(24);
    lines(127, 24);

    // Zero target width: error within two cycles, step kept
    cfg_w_out_i  = 11'd0;
    cfg_update_i = 1'b1;
    blank(2);
    chk("zero_err", err_o, 1);
    chk("zero_busy", busy_o, 0);
    chk("zero_step", scale_step_h_o, 4096);
    cfg_w_out_i = 11'd18;

    // Frame 5: line length changes 24 -> 32 mid-frame
    pix(1'b1, 1'b1, 1'b1);
    chk("f5_no_apply", scale_step_h_o, 4096);
    tail(24);
    lines(10, 24);
    lines(3, 32);
    chk("w_in_32", w_in_o, 32);
    lines(114, 32);

    // Frame 6: 32*4096/18 = 7281, then reset while dividing
    chk("f6_pre_step", scale_step_h_o, 4096);
    chk("f6_pre_busy", busy_o, 1);
    pix(1'b1, 1'b1, 1'b1);
    chk("f6_step_7281", scale_step_h_o, 7281);
    chk("f6_err_clr", err_o, 0);
    cfg_update_i = 1'b1;
    beats(5);
    chk("div_busy", busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_step", scale_step_h_o, 4096);
    chk("arst_busy", busy_o, 0);
    chk("arst_w_in", w_in_o, 0);
    blank(3);
    rst_n = 1'b1;
    blank(40);
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_step", scale_step_h_o, 4096);

    // Frame 7: first vs after release leaves the step alone
    pix(1'b1, 1'b1, 1'b1);
    chk("f7_first_vs", scale_step_h_o, 4096);
    tail(32);
    lines(9, 32);
    cfg_update_i = 1'b1;
    lines(118, 32);
    chk("f7_w_in", w_in_o, 32);

    // Frame 8/9: normal operation restored
    chk("f8_pre_step", scale_step_h_o, 4096);
    pix(1'b1, 1'b1, 1'b1);
    chk("f8_step", scale_step_h_o, 7281);
    tail(32);
    lines(127, 32);
    pix(1'b1, 1'b1, 1'b1);
    chk("f9_step", scale_step_h_o, 7281);
    chk("f9_busy", busy_o, 0);
    chk("f9_err", err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scaler_h_ctrl.md
Name: scaler_h_ctrl

Overview:
- Frame-synchronous controller that drives the `scale_step_h` configuration input of the horizontal scaler.
- Measures the active input line width from the scaler's input video strobes (de/hs/vs).
- Computes step = floor(w_in * PIXEL_STEP / w_out) with a sequential divider and applies it only at a frame boundary, so the scaler never sees a mid-frame change.
- Sits beside scaler_h on the same input video bus; fed by a software-written target width.

Parameters:
- PIXEL_STEP, 4096, fixed-point unity step; must be a power of two; FRAC_BITS = log2(PIXEL_STEP).
- LINE_WIDTH, 11, width of line-pixel counters and cfg_w_out.
- STEP_WIDTH, 16, width of scale_step_h.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- de_i  in  1  input pixel valid.
- hs_i  in  1  line start; valid only when de_i=1, marks first pixel of a line.
- vs_i  in  1  frame start; valid only when de_i=1 and hs_i=1.
- cfg_w_out_i  in  LINE_WIDTH  target output line width in pixels.
- cfg_update_i  in  1  one-cycle pulse requesting recompute with current cfg_w_out_i.
- scale_step_h_o  out  STEP_WIDTH  step to scaler_h.
- w_in_o  out  LINE_WIDTH  last stable measured input width.
- busy_o  out  1  high while dividing or waiting for vs.
- err_o  out  1  sticky; cleared by the next successful apply.

Behaviour:
- Reset values:
  - scale_step_h_o = PIXEL_STEP (1:1).
  - w_in_o = 0; busy_o = 0; err_o = 0.
  - Counters 0; FSM in IDLE.
- Line measurement:
  - pix_cnt increments on de_i.
  - On de_i&&hs_i: if pix_cnt != 0, capture cand = pix_cnt; then pix_cnt <= 1.
  - Width is stable when two consecutive captures are equal; then w_in_o <= cand.
  - pix_cnt saturates at all-ones and never wraps.
- Trigger: IDLE -> DIV on the cycle after either of these:
  - cfg_update_i pulses;
  - w_in_o changes to a new nonzero value.
- Trigger handling:
  - A trigger arriving in DIV or WAIT_VS sets a pending flag.
  - The pending flag is served on return to IDLE.
- FSM states:
  - IDLE: busy_o = 0. Waits for a trigger.
  - DIV: latch w_out = cfg_w_out_i and num = w_in_o << FRAC_BITS.
    - If w_out == 0 or w_in_o == 0: set err_o, return to IDLE; scale_step_h_o unchanged.
    - Otherwise run a restoring divider, one quotient bit per cycle, LINE_WIDTH+FRAC_BITS cycles (23 at defaults).
    - Then go to WAIT_VS with step_shadow = quotient.
  - Overflow: if quotient > 2^STEP_WIDTH-1, step_shadow = all-ones and err_o is set at apply.
  - WAIT_VS: on de_i&&hs_i&&vs_i, scale_step_h_o <= step_shadow on the next edge (1-cycle latency from the vs beat). Clear err_o unless overflow, then go to IDLE.
- Simultaneous events:
  - A vs beat in the cycle DIV completes is not used; apply waits for the following frame.
  - cfg_update_i coincident with the vs apply sets pending.
- cfg_w_out_i is sampled only on DIV entry; later changes are ignored until the next trigger.
- Reset mid-operation: the divider aborts; all outputs return to reset values, including scale_step_h_o = PIXEL_STEP.

Decomposition:
- Package scaler_pkg holds:
  - ctrl_state_t enum {IDLE, DIV, WAIT_VS};
  - the FRAC_BITS function ($clog2 of PIXEL_STEP);
  - DEFAULT_PIXEL_STEP constant, shared with scaler_h.
- One sub-module: seq_divider_u, a parameterised unsigned restoring divider.
  - Ports: clk, rst_n, start, num, den, busy, done, quot.
- The controller keeps the measurement, FSM and apply logic.

Test Plan:
- Stream 24-pixel lines, 128-line frames, cfg_w_out=18, pulse update. Required:
  - w_in_o = 24 after 2 lines;
  - scale_step_h_o = 5461 (0x1555) exactly 1 cycle after the next vs beat;
  - value unchanged before that beat.
- cfg_w_out = 24 with w_in = 24 -> step 4096; err_o = 0.
- cfg_w_out = 1 with w_in = 24 -> quotient 98304 -> scale_step_h_o = 0xFFFF at vs; err_o = 1.
- cfg_w_out = 0 -> err_o = 1 within 2 cycles; scale_step_h_o keeps its previous value; busy_o returns to 0.
- Change line length 24 -> 32 mid-frame -> w_in_o = 32 after 2 lines; auto recompute; step = 32*4096/18 = 7281 applied at the next vs.
- Deassert rst_n during DIV -> scale_step_h_o = 4096 and busy_o = 0 immediately. After release, the bench must assert all of the following:
  - no apply occurs without a new trigger;
  - the first vs seen after release does not change the step;
  - pulsing cfg_update_i after release restores normal operation.
